// File: rtl/alu_result_fifo.sv
// In-order capture FIFO for ALU results with op code and N/Z/C/V flags.
// Ports: clk/rst; in_* valid/ready push side; out_* valid/ready pop side;
//   count = occupancy; sticky_flags = OR of accepted flags (sticky_clr clears);
//   drop_cnt = saturating count of offered-but-refused results.
module alu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [7:0]       in_result,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_op,
   output logic [7:0]       out_result,
   output logic [3:0]       out_flags,
   output logic [CNT_W-1:0] count,
   output logic [3:0]       sticky_flags,
   input  logic             sticky_clr,
   output logic [7:0]       drop_cnt
);

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] res;
      logic [3:0] flags;
   } ent_t;

   ent_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_sticky;
   logic [7:0]       r_drop;

   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic             w_empty;
   ent_t             w_head;

   // Full FIFO refuses even when a pop is happening: no pass-through.
   assign in_ready  = !rst && (r_count < CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_drop    = in_valid && !in_ready && !rst;

   // Gate the head with occupancy so stale storage never shows.
   assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign out_op     = w_head.op;
   assign out_result = w_head.res;
   assign out_flags  = w_head.flags;

   assign count        = r_count;
   assign sticky_flags = r_sticky;
   assign drop_cnt     = r_drop;

   // Storage needs no reset; reads are masked while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{op: in_op, res: in_result, flags: in_flags};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_sticky <= '0;
         r_drop   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_sticky <= (sticky_clr ? 4'h0 : r_sticky)
                   | (w_push ? in_flags : 4'h0);
         if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed plan plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_alu_result_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_op = '0;
   logic [7:0] in_result = '0;
   logic [3:0] in_flags = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [2:0] out_op;
   logic [7:0] out_result;
   logic [3:0] out_flags;
   logic [2:0] count;
   logic [3:0] sticky_flags;
   logic       sticky_clr = 1'b0;
   logic [7:0] drop_cnt;

   int total = 0;
   int bad = 0;

   alu_result_fifo #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_result(in_result), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .out_result(out_result), .out_flags(out_flags),
      .count(count), .sticky_flags(sticky_flags),
      .sticky_clr(sticky_clr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] res;
      logic [3:0] fl;
   } ent_t;

   ent_t q[$];
   logic [3:0] m_sticky = '0;
   int         m_drop = 0;
   bit         m_ok = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue semantics straight from the rules.
   always @(posedge clk) begin
      bit acc;
      bit take;
      if (rst) begin
         q.delete();
         m_sticky = '0;
         m_drop = 0;
         m_ok = 1;
      end else begin
         acc  = in_valid && (q.size() < DEPTH);
         take = (q.size() != 0) && out_ready;
         if (take) void'(q.pop_front());
         if (acc) q.push_back('{in_op, in_result, in_flags});
         m_sticky = (sticky_clr ? 4'h0 : m_sticky) | (acc ? in_flags : 4'h0);
         if (in_valid && !acc && m_drop < 255) m_drop++;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("in_ready", int'(in_ready), int'(!rst && q.size() < DEPTH));
         chk("out_valid", int'(out_valid), int'(q.size() != 0));
         chk("count", int'(count), q.size());
         chk("out_op", int'(out_op), q.size() ? int'(q[0].op) : 0);
         chk("out_result", int'(out_result), q.size() ? int'(q[0].res) : 0);
         chk("out_flags", int'(out_flags), q.size() ? int'(q[0].fl) : 0);
         chk("sticky", int'(sticky_flags), int'(m_sticky));
         chk("drop_cnt", int'(drop_cnt), m_drop);
      end
   end

   // Apply inputs, let one rising edge pass, return just after the falling edge.
   task automatic step(input bit v, input int op, input int res, input int fl,
                       input bit ordy, input bit clr, input bit r);
      rst        = r;
      in_valid   = v;
      in_op      = 3'(op);
      in_result  = 8'(res);
      in_flags   = 4'(fl);
      out_ready  = ordy;
      sticky_clr = clr;
      @(negedge clk);
      #1;
   endtask

   initial begin
      // 1: reset with an offer pending
      step(1, 7, 8'h99, 4'hF, 0, 0, 1);
      step(1, 7, 8'h99, 4'hF, 0, 0, 1);
      chk("p1_rdy_in_rst", int'(in_ready), 0);
      chk("p1_drop_in_rst", int'(drop_cnt), 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("p1_count", int'(count), 0);
      chk("p1_ovalid", int'(out_valid), 0);
      chk("p1_ores", int'(out_result), 0);
      chk("p1_sticky", int'(sticky_flags), 0);
      chk("p1_rdy", int'(in_ready), 1);

      // 2: three pushes, then in-order drain
      step(1, 0, 8'h12, 4'h0, 0, 0, 0);
      step(1, 1, 8'h80, 4'h8, 0, 0, 0);
      step(1, 1, 8'h00, 4'h6, 0, 0, 0);
      chk("p2_count", int'(count), 3);
      chk("p2_head", int'(out_result), 8'h12);
      chk("p2_op", int'(out_op), 0);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("p2_head2", int'(out_result), 8'h80);
      chk("p2_flags2", int'(out_flags), 4'h8);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("p2_head3", int'(out_result), 8'h00);
      chk("p2_flags3", int'(out_flags), 4'h6);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("p2_count0", int'(count), 0);
      chk("p2_ovalid0", int'(out_valid), 0);

      // 3: fill, drops, saturation
      for (int i = 0; i < 4; i++) step(1, 2, 8'hA0 + i, 4'h0, 0, 0, 0);
      chk("p3_count", int'(count), 4);
      chk("p3_rdy", int'(in_ready), 0);
      for (int i = 0; i < 3; i++) step(1, 5, 8'h55, 4'hF, 0, 0, 0);
      chk("p3_drop3", int'(drop_cnt), 3);
      chk("p3_sticky", int'(sticky_flags), 4'hE);
      for (int i = 0; i < 300; i++) step(1, 5, 8'h55, 4'hF, 0, 0, 0);
      chk("p3_drop_sat", int'(drop_cnt), 255);
      for (int i = 0; i < 4; i++) begin
         chk("p3_drain", int'(out_result), 8'hA0 + i);
         step(0, 0, 0, 0, 1, 0, 0);
      end
      chk("p3_empty", int'(count), 0);

      // 4: simultaneous push/pop, and push+ready at empty
      step(1, 3, 8'h10, 4'h0, 0, 0, 0);
      step(1, 3, 8'h11, 4'h0, 0, 0, 0);
      step(1, 3, 8'h33, 4'h0, 1, 0, 0);
      chk("p4_count2", int'(count), 2);
      chk("p4_head", int'(out_result), 8'h11);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("p4_head2", int'(out_result), 8'h33);
      step(0, 0, 0, 0, 1, 0, 0);
      chk("p4_empty", int'(count), 0);
      step(1, 4, 8'h33, 4'h0, 1, 0, 0);
      chk("p4_count1", int'(count), 1);
      chk("p4_res", int'(out_result), 8'h33);
      step(0, 0, 0, 0, 1, 0, 0);

      // 5: sticky flags
      step(0, 0, 0, 0, 1, 1, 0);
      chk("p5_clr", int'(sticky_flags), 0);
      step(1, 0, 8'h01, 4'h2, 1, 0, 0);
      step(1, 0, 8'h02, 4'h1, 1, 0, 0);
      chk("p5_or", int'(sticky_flags), 4'h3);
      step(1, 0, 8'h03, 4'h4, 1, 1, 0);
      chk("p5_clr_push", int'(sticky_flags), 4'h4);
      step(0, 0, 0, 0, 1, 1, 0);
      chk("p5_clr2", int'(sticky_flags), 0);
      step(0, 0, 0, 0, 1, 0, 0);

      // 6: wrap through back-to-back traffic, then reset mid-fill
      for (int i = 0; i < 10; i++) begin
         step(1, 6, i, 4'h0, 1, 0, 0);
         chk("p6_head", int'(out_result), i);
         chk("p6_cnt", int'(count), 1);
      end
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 8'hC0 + i, 4'h0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("p6_rst_cnt", int'(count), 0);
      chk("p6_rst_ov", int'(out_valid), 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 1, 0, 0);
         chk("p6_no_out", int'(out_valid), 0);
      end

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 255), $urandom_range(0, 15),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 99) == 0);
      end
      step(0, 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Downstream capture stage for the combinational 8-bit ALU. Registers each ALU result together with its op code and N/Z/C/V flags into a small in-order FIFO. Hands entries to the consumer (register-file writeback / display logic) over a valid/ready handshake. Also keeps sticky flag status and a saturating count of dropped results.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
PTR_W, 2, pointer width; equals log2(DEPTH).
CNT_W, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  the ALU result on in_* is offered this cycle.
in_ready  output  1  FIFO can accept an entry this cycle.
in_op  input  3  op code that produced the result.
in_result  input  8  ALU result.
in_flags  input  4  ALU flags {N,Z,C,V}, where bit3 = N and bit0 = V.
out_valid  output  1  the head entry is present on out_*.
out_ready  input  1  consumer takes the head entry this cycle.
out_op  output  3  op code of the head entry.
out_result  output  8  result of the head entry.
out_flags  output  4  flags of the head entry.
count  output  CNT_W  current occupancy, 0..DEPTH.
sticky_flags  output  4  OR of in_flags over all entries accepted since the last reset or clear.
sticky_clr  input  1  clears sticky_flags.
drop_cnt  output  8  number of offered results that were not accepted; saturates at 255.

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr, rd_ptr, count, sticky_flags and drop_cnt all go to 0.
  - Storage contents are don't-care.
  - out_op, out_result and out_flags read 0 while count=0, so they are 0 after reset.
  - Reset mid-operation discards every stored entry; nothing is popped to the consumer.
- in_ready = !rst && (count < DEPTH). It is combinational from registered state plus rst.
  - A full FIFO does not accept a push in the same cycle as a pop (no pass-through).
- push = in_valid && in_ready.
  - Writes {in_op, in_result, in_flags} at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap).
- out_valid = (count != 0).
  - out_* show the entry at rd_ptr and are driven from registered storage.
  - Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- pop = out_valid && out_ready. rd_ptr increments modulo DEPTH.
  - out_ready while empty has no effect.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and ordering is preserved.
  - At count=0, a push together with out_ready is not a pop; count becomes 1.
- Drops: when in_valid=1 and in_ready=0 (full, or rst high), the entry is discarded.
  - drop_cnt increments by 1 per dropped cycle and holds at 255.
  - drop_cnt is not incremented while rst=1; reset has priority.
- sticky_flags:
  - next = (sticky_clr ? 0 : sticky_flags) | (push ? in_flags : 0).
  - A clear and a push in the same cycle leave exactly the pushed flags.
  - A dropped entry never affects sticky_flags.
- Data is stored verbatim. No arithmetic is applied to result or flags.
- No X must propagate to out_* or in_ready after the first reset edge.

Test Plan:
1. Assert rst for 2 cycles with in_valid=1 -> in_ready=0 during reset, drop_cnt=0. After release: count=0, out_valid=0, out_result=0x00, sticky_flags=0x0, in_ready=1.
2. Push (op=0, 0x12, flags 0x0), (op=1, 0x80, flags 0x8), (op=1, 0x00, flags 0x6) with out_ready=0 -> count=3, head is 0x12 op 0. Then hold out_ready=1 -> 0x12, 0x80, 0x00 popped in order, count=0, out_valid=0.
3. Fill with 0xA0..0xA3 -> count=4, in_ready=0. Offer 0x55 for 3 cycles -> drop_cnt=3, 0x55 never appears, sticky_flags unchanged. Then force 300 drop cycles -> drop_cnt=255.
4. At count=2, push 0x33 and pop in the same cycle -> count stays 2, pop order unchanged. At count=0, in_valid=1 and out_ready=1 -> count=1, out_result=0x33 next cycle.
5. Push flags 0x2 then 0x1 -> sticky_flags=0x3. Assert sticky_clr together with a push of flags 0x4 -> sticky_flags=0x4. Assert sticky_clr with no push -> 0x0.
6. Run 10 back-to-back push/pop pairs with results 0x00..0x09 -> pointers wrap and output order is exact. Then push 3 entries and assert rst for one cycle -> next cycle count=0, out_valid=0, and no entry is ever presented.
